// File: rtl/mips_fetch_stage.sv
// rtl/mips_fetch_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
//
// Owns the PC and fetches one instruction word per transfer over a req/ack
// handshake, then presents the word, its PC+PC_INC and the opcode field to decode.
// Honours a hazard stall (hold IF/ID and PC) and a branch/jump redirect
// (flush IF/ID and refetch from redirect_pc).
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  fetch request, held until acknowledged
//   imem_addr    out  fetch address (current PC)
//   imem_ack     in   memory accepts request; rdata valid in the same cycle
//   imem_rdata   in   fetched instruction word
//   stall        in   hazard hold
//   redirect     in   taken branch/jump: flush and refetch
//   redirect_pc  in   redirect target
//   if_id_valid  out  IF/ID holds a real instruction
//   if_id_instr  out  IF/ID instruction, 0 for a bubble
//   if_id_pc4    out  instruction address plus PC_INC
//   opcode       out  if_id_instr[31:26]

module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  opcode
);

  // IDLE: one cycle after reset release. REQ: request outstanding.
  // HOLD: word captured under stall, request dropped.
  // DROP: redirect arrived mid-request; finish the handshake and discard the data.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + PC_INC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_instr_d   = buf_instr_q;
    buf_valid_d   = buf_valid_q;
    pending_pc_d  = pending_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            // Handshake completes this cycle; the word is simply dropped.
            pc_d = redirect_pc;
          end else begin
            // Address must stay stable until ack, so park the target.
            pending_pc_d = redirect_pc;
            state_d      = ST_DROP;
          end
        end else if (imem_ack) begin
          if (stall) begin
            buf_instr_d = imem_rdata;
            buf_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = imem_rdata;
            if_id_pc4_d   = pc_inc;
            pc_d          = pc_inc;
          end
        end else if (!stall) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = 32'h0;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          buf_valid_d = 1'b0;
          pc_d        = redirect_pc;
          state_d     = ST_REQ;
        end else if (!stall) begin
          if_id_valid_d = buf_valid_q;
          if_id_instr_d = buf_instr_q;
          if_id_pc4_d   = pc_inc;
          pc_d          = pc_inc;
          buf_valid_d   = 1'b0;
          state_d       = ST_REQ;
        end
      end

      ST_DROP: begin
        if (redirect) begin
          pending_pc_d = redirect_pc;
        end
        if (imem_ack) begin
          // A redirect in the ack cycle is newer than the parked target.
          pc_d    = redirect ? redirect_pc : pending_pc_q;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush overrides every other IF/ID update, stall included.
    if (redirect) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      buf_instr_q   <= 32'h0;
      buf_valid_q   <= 1'b0;
      pending_pc_q  <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= 32'h0;
      if_id_pc4_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_instr_q   <= buf_instr_d;
      buf_valid_q   <= buf_valid_d;
      pending_pc_q  <= pending_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign imem_addr   = pc_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign opcode      = if_id_instr_q[31:26];

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb/tb_mips_fetch_stage.sv - scoreboard bench for mips_fetch_stage

module tb_mips_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  opcode;

  always #5 clk = ~clk;

  mips_fetch_stage #(.RESET_PC(RESET_PC), .PC_INC(32'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .opcode(opcode)
  );

  // Instruction memory contents: low addresses return their own address,
  // address 8 holds a load-word, everything else a scrambled pattern.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h8) return 32'h8C22_0004;
    if (a < 32'h40) return a;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  // Reference model: which fetches are delivered and where the next fetch goes.
  bit          started = 1'b0;
  bit          holding = 1'b0;
  bit          dropping = 1'b0;
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] pending = 32'h0;
  bit          prev_stall = 1'b0;
  bit          prev_redir = 1'b0;
  logic        snap_valid = 1'b0;
  logic [31:0] snap_instr = 32'h0;
  logic [31:0] snap_pc4 = 32'h0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void model_reset();
    started  = 1'b0;
    holding  = 1'b0;
    dropping = 1'b0;
    exp_addr = RESET_PC;
    pending  = 32'h0;
    exp_q.delete();
  endfunction

  // Model update on each rising edge, from the inputs the DUT sees at that edge.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      prev_stall = stall;
      prev_redir = redirect;
      if (!rst_n) begin
        model_reset();
      end else if (!started) begin
        started = 1'b1;
      end else if (holding) begin
        if (redirect) begin
          exp_q.delete();
          exp_addr = redirect_pc;
          holding  = 1'b0;
        end else if (!stall) begin
          holding = 1'b0;
        end
      end else if (dropping) begin
        if (imem_ack) begin
          exp_addr = redirect ? redirect_pc : pending;
          dropping = 1'b0;
        end else if (redirect) begin
          pending = redirect_pc;
        end
      end else if (redirect) begin
        if (imem_ack) exp_addr = redirect_pc;
        else begin
          pending  = redirect_pc;
          dropping = 1'b1;
        end
      end else if (imem_ack) begin
        e.instr = mem_f(exp_addr);
        e.pc4   = exp_addr + 32'd4;
        exp_q.push_back(e);
        exp_addr = exp_addr + 32'd4;
        holding  = stall;
      end
    end
  end

  // Monitor: compares DUT outputs against the model on every falling edge.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("imem_req", {31'd0, imem_req}, {31'd0, started && !holding});
        if (started && !holding) chk("imem_addr", imem_addr, exp_addr);
        if (prev_redir) begin
          chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
          chk("flush_instr", if_id_instr, 32'h0);
        end else if (prev_stall) begin
          chk("stall_valid", {31'd0, if_id_valid}, {31'd0, snap_valid});
          chk("stall_instr", if_id_instr, snap_instr);
          chk("stall_pc4", if_id_pc4, snap_pc4);
        end else if (if_id_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_load: got instr %h pc4 %h, expected no load", if_id_instr, if_id_pc4);
          end else begin
            e = exp_q.pop_front();
            chk("load_instr", if_id_instr, e.instr);
            chk("load_pc4", if_id_pc4, e.pc4);
            chk("load_opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
          end
        end else begin
          chk("bubble_instr", if_id_instr, 32'h0);
          chk("bubble_opcode", {26'd0, opcode}, 32'd0);
        end
      end
      snap_valid = if_id_valid;
      snap_instr = if_id_instr;
      snap_pc4   = if_id_pc4;
    end
  end

  task automatic step(input bit a, input bit s, input bit r, input logic [31:0] rpc);
    @(negedge clk);
    #2;
    imem_ack    = a;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    model_reset();
    imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    rst_n = 1'b0;
    imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    chk("por_imem_req", {31'd0, imem_req}, 32'd0);
    chk("por_valid", {31'd0, if_id_valid}, 32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    imem_ack = 1'b1;

    // Zero-wait start, stall capture at addr 8, release.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Three wait states at 0x10.
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    // Redirect while waiting at 0x20.
    step(0, 0, 1, 32'h100);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    // Capture at 0x100, then redirect+stall in HOLD.
    step(1, 1, 0, 0);
    step(0, 1, 1, 32'h200);
    step(1, 0, 0, 0);
    // Enter DROP, then reset asynchronously.
    step(0, 0, 1, 32'h300);
    async_reset();
    step(1, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0);

    // Randomized traffic, including wrap-around and unaligned targets.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: rpc = 32'hFFFF_FFF8 + {29'd0, $urandom_range(0, 1) == 0 ? 3'd0 : 3'd4};
        1: rpc = $urandom;
        default: rpc = $urandom & 32'h0000_FFFC;
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, rpc);
    end

    repeat (6) step(1, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
